// File: rtl/mult_div_unit_if.sv
// Operand, HI/LO write and result bundle between the datapath and the multiply/divide unit.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none here; the requester watches busy and holds off start.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] input1;
   logic [WIDTH-1:0] input2;
   logic             hi_we;
   logic             lo_we;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // Requester side: issues operations and HI/LO writes, observes results.
   modport master (
      output start, op, input1, input2, hi_we, lo_we,
      input  busy, done, hi, lo
   );

   // Unit side.
   modport slave (
      input  start, op, input1, input2, hi_we, lo_we,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO, plus direct MTHI/MTLO writes.
// Latency: WIDTH cycles from the start edge to HI/LO update with a one-cycle done pulse.
// Backpressure: busy high while running; start and HI/LO writes are ignored until idle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic           clk,
   input logic           reset,
   mult_div_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state;
   state_t             next_state;
   logic [CW-1:0]      cnt;
   logic               last;

   // Latched at start: operation class, sign fixes and divide-by-zero.
   logic               is_div;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   logic [WIDTH-1:0]   raw_a;
   logic [WIDTH-1:0]   opb;

   // Multiply: 64-bit accumulator, multiplier in the low half shifts out.
   // Divide: low half holds dividend bits shifting in quotient bits; rem is the partial remainder.
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;

   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               done_r;

   // Start-cycle operand magnitudes.
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   // One-iteration datapath results.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign last     = (cnt == CW'(WIDTH - 1));
   assign bus.busy = (state == RUN);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

   // Signed ops work on magnitudes; signs are reapplied on the final iteration.
   always_comb begin
      mag_a = bus.input1;
      mag_b = bus.input2;
      if (bus.op[0] && bus.input1[WIDTH-1]) mag_a = -bus.input1;
      if (bus.op[0] && bus.input2[WIDTH-1]) mag_b = -bus.input2;
   end

   // One shift-add / restoring shift-subtract step, plus final sign correction.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {rem, acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
      div_ge    = ~div_diff[WIDTH];
      // When the subtract fails the shifted remainder is below the divisor, so it fits WIDTH bits.
      rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_next  = {acc[WIDTH-2:0], div_ge};
      prod_fix  = neg_q ? -mul_next : mul_next;
      quo_fix   = neg_q ? -quo_next : quo_next;
      rem_fix   = neg_r ? -rem_next : rem_next;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state: IDLE accepts start, RUN leaves after the last iteration.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = RUN;
         RUN:     if (last)      next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operand latch, iteration registers, HI/LO and done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         raw_a    <= '0;
         opb      <= '0;
         acc      <= '0;
         rem      <= '0;
         hi_r     <= '0;
         lo_r     <= '0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               // start takes priority over any HI/LO write in the same cycle.
               cnt      <= '0;
               is_div   <= bus.op[1];
               neg_q    <= bus.op[0] & (bus.input1[WIDTH-1] ^ bus.input2[WIDTH-1]);
               neg_r    <= bus.op[0] & bus.input1[WIDTH-1];
               div_zero <= (bus.input2 == '0);
               raw_a    <= bus.input1;
               opb      <= mag_b;
               acc      <= {{WIDTH{1'b0}}, mag_a};
               rem      <= '0;
            end else begin
               if (bus.hi_we) hi_r <= bus.input1;
               if (bus.lo_we) lo_r <= bus.input1;
            end
         end else begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
               acc[WIDTH-1:0] <= quo_next;
               rem            <= rem_next;
            end else begin
               acc <= mul_next;
            end
            if (last) begin
               done_r <= 1'b1;
               if (!is_div) begin
                  hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_r <= prod_fix[WIDTH-1:0];
               end else if (div_zero) begin
                  hi_r <= raw_a;
                  lo_r <= '1;
               end else begin
                  hi_r <= rem_fix;
                  lo_r <= quo_fix;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: per-cycle model compare plus literal result pins.
// Latency: stimulus drives 1ns after the rising edge, outputs compared on the falling edge.
// Backpressure: random start / HI-LO write noise is injected while the unit is busy.
module tb_mult_div_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(32)) ifc ();
   mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(ifc));

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   // Reference: architectural HI/LO plus a countdown to the pending result.
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_left = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] p_hi = '0;
   logic [31:0] p_lo = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   function automatic void model_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                        output logic [31:0] rh, output logic [31:0] rl);
      logic [63:0] up;
      longint      sp, sa, sb, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin up = {32'b0, a} * {32'b0, b}; rh = up[63:32]; rl = up[31:0]; end
         2'b01: begin sp = sa * sb; up = sp; rh = up[63:32]; rl = up[31:0]; end
         2'b10: begin
            if (b == 0) begin rh = a; rl = '1; end
            else begin rh = a % b; rl = a / b; end
         end
         default: begin
            if (b == 0) begin rh = a; rl = '1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rh = '0; rl = 32'h8000_0000; end
            else begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
         end
      endcase
   endfunction

   // Model update on each rising edge from the same sampled inputs the DUT sees.
   always @(posedge clk) begin
      logic [31:0] rh, rl;
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_hi = '0; m_lo = '0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
            end
         end else if (ifc.start) begin
            model_result(ifc.op, ifc.input1, ifc.input2, rh, rl);
            p_hi = rh; p_lo = rl; m_busy = 1'b1; m_left = 32;
         end else begin
            if (ifc.hi_we) m_hi = ifc.input1;
            if (ifc.lo_we) m_lo = ifc.input1;
         end
      end
   end

   // Per-cycle output compare.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("cyc_busy", {31'b0, ifc.busy}, {31'b0, m_busy});
         chk("cyc_done", {31'b0, ifc.done}, {31'b0, m_done});
         chk("cyc_hi", ifc.hi, m_hi);
         chk("cyc_lo", ifc.lo, m_lo);
      end
   end

   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      ifc.op = op; ifc.input1 = a; ifc.input2 = b; ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0; ifc.input1 = $urandom; ifc.input2 = $urandom; ifc.op = 2'($urandom);
   endtask

   task automatic wait_done(output int busy_cycles, output bit ok);
      busy_cycles = 0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ifc.done) begin ok = 1'b1; break; end
         if (ifc.busy) busy_cycles++;
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done within 40 cycles, expected one");
      end
      @(posedge clk); #1;
   endtask

   task automatic run_lit(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
      int bc; bit ok;
      start_op(op, a, b);
      wait_done(bc, ok);
      chk({name, "_hi"}, ifc.hi, eh);
      chk({name, "_lo"}, ifc.lo, el);
      chk({name, "_busycycles"}, 32'(bc), 32'd32);
   endtask

   logic [31:0] pick;

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int bc, dones; bit ok;
      ifc.start = 1'b0; ifc.op = 2'b00; ifc.input1 = '0; ifc.input2 = '0;
      ifc.hi_we = 1'b0; ifc.lo_we = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, ifc.busy}, 32'd0);
      chk("rst_done", {31'b0, ifc.done}, 32'd0);
      chk("rst_hi", ifc.hi, 32'd0);
      chk("rst_lo", ifc.lo, 32'd0);
      cmp_en = 1'b1;
      @(posedge clk); #1 reset = 1'b0;

      run_lit("multu_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_lit("mult_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
      run_lit("mult_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_lit("divu_100_7", 2'b10, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E);
      run_lit("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_lit("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_lit("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);

      // Idle MTHI: HI loads next cycle, LO keeps the divide-by-zero quotient, no done.
      ifc.input1 = 32'hAAAA_BBBB; ifc.hi_we = 1'b1;
      @(posedge clk); #1 ifc.hi_we = 1'b0;
      @(negedge clk);
      chk("mthi_hi", ifc.hi, 32'hAAAA_BBBB);
      chk("mthi_lo", ifc.lo, 32'hFFFF_FFFF);
      chk("mthi_done", {31'b0, ifc.done}, 32'd0);

      // MTHI and MTLO together.
      @(posedge clk); #1;
      ifc.input1 = 32'h1357_9BDF; ifc.hi_we = 1'b1; ifc.lo_we = 1'b1;
      @(posedge clk); #1 ifc.hi_we = 1'b0; ifc.lo_we = 1'b0;
      @(negedge clk);
      chk("mthilo_hi", ifc.hi, 32'h1357_9BDF);
      chk("mthilo_lo", ifc.lo, 32'h1357_9BDF);

      // start with hi_we in the same cycle: the write is dropped.
      @(posedge clk); #1;
      ifc.hi_we = 1'b1;
      ifc.op = 2'b00; ifc.input1 = 32'd2; ifc.input2 = 32'd2; ifc.start = 1'b1;
      @(posedge clk); #1 ifc.start = 1'b0; ifc.hi_we = 1'b0;
      @(negedge clk);
      chk("startwe_hi", ifc.hi, 32'h1357_9BDF);
      wait_done(bc, ok);
      chk("startwe_res_lo", ifc.lo, 32'd4);

      // Second start at k+5 is ignored.
      start_op(2'b00, 32'd6, 32'd7);
      repeat (4) @(posedge clk);
      #1 ifc.op = 2'b10; ifc.input1 = 32'd99; ifc.input2 = 32'd5; ifc.start = 1'b1;
      @(posedge clk); #1 ifc.start = 1'b0;
      wait_done(bc, ok);
      chk("restart_hi", ifc.hi, 32'd0);
      chk("restart_lo", ifc.lo, 32'd42);
      chk("restart_busycycles", 32'(bc), 32'd27);

      // MTLO while busy is ignored.
      start_op(2'b00, 32'd3, 32'd5);
      repeat (3) @(posedge clk);
      #1 ifc.input1 = 32'hDEAD_BEEF; ifc.lo_we = 1'b1;
      @(posedge clk); #1 ifc.lo_we = 1'b0;
      wait_done(bc, ok);
      chk("mtlo_busy_lo", ifc.lo, 32'd15);

      // Reset at edge k+10 of a MULTU.
      start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", {31'b0, ifc.busy}, 32'd0);
      chk("midrst_hi", ifc.hi, 32'd0);
      chk("midrst_lo", ifc.lo, 32'd0);
      dones = 0;
      repeat (40) begin @(negedge clk); if (ifc.done) dones++; end
      chk("midrst_nodone", 32'(dones), 32'd0);
      @(posedge clk); #1;
      run_lit("after_rst", 2'b01, 32'hFFFF_FFF9, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFC1);

      // Randomized operations with noise on start/hi_we/lo_we while busy and in idle gaps.
      for (int n = 0; n < 80; n++) begin
         start_op(2'($urandom), rand_operand(), rand_operand());
         ok = 1'b0;
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.done) begin ok = 1'b1; break; end
            ifc.start = ($urandom_range(0, 3) == 0);
            ifc.hi_we = ($urandom_range(0, 3) == 0);
            ifc.lo_we = ($urandom_range(0, 3) == 0);
            ifc.input1 = $urandom; ifc.input2 = $urandom; ifc.op = 2'($urandom);
         end
         ifc.start = 1'b0; ifc.hi_we = 1'b0; ifc.lo_we = 1'b0;
         if (!ok) begin
            checks++; errors++;
            $display("FAIL rand_done_timeout: got no done within 40 cycles, expected one");
         end
         @(posedge clk); #1;
         repeat ($urandom_range(0, 2)) begin
            pick = $urandom;
            ifc.input1 = pick; ifc.hi_we = pick[0]; ifc.lo_we = pick[1];
            @(posedge clk); #1 ifc.hi_we = 1'b0; ifc.lo_we = 1'b0;
         end
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
